// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the four-master shared bus: active-low requests in, registered one-hot active-low grants out.
// Define BUS_ARB_TENURE_EN to preempt an owner after TENURE_MAX contended cycles once s_as_ shows the bus idle.
module bus_arbiter_rr #(
    parameter int unsigned TENURE_MAX = 16,
    parameter int unsigned TENURE_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    input  logic       s_as_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       grnt_chg
);

    logic [3:0] req;
    logic [3:0] grnt_n;
    logic       others_req;
    logic       found;
    logic [1:0] next_owner;
    logic [1:0] cand;
    logic       rotate;
    logic       change;

    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;
    assign others_req = |(req & ~(4'b0001 << owner));

    // Search starts just past the owner, so index order never matters.
    always_comb begin
        found      = 1'b0;
        next_owner = owner;
        cand       = '0;
        for (int unsigned i = 1; i < 4; i++) begin
            cand = owner + 2'(i);
            if (!found && req[cand]) begin
                found      = 1'b1;
                next_owner = cand;
            end
        end
    end

`ifdef BUS_ARB_TENURE_EN
    logic [TENURE_W-1:0] tenure;
    logic                preempt;

    assign preempt = (tenure == TENURE_W'(TENURE_MAX)) && s_as_;
    assign rotate  = !req[owner] || preempt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tenure <= '0;
        end else if (change || !others_req) begin
            tenure <= '0;
        end else if (tenure != TENURE_W'(TENURE_MAX)) begin
            tenure <= tenure + TENURE_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = s_as_ ^ (TENURE_MAX > 0) ^ (TENURE_W > 0) ^ others_req;
    assign rotate     = !req[owner];
`endif

    assign change = rotate && found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner    <= '0;
            grnt_n   <= 4'b1110;
            grnt_chg <= 1'b0;
        end else begin
            grnt_chg <= change;
            if (change) begin
                owner  <= next_owner;
                grnt_n <= ~(4'b0001 << next_owner);
            end
        end
    end

endmodule
